// File: rtl/lfsr_word_gen_if.sv
// Handshake/bus bundle for lfsr_word_gen.
//   seed_load/seed_in : load a new LFSR state (IDLE/HOLD only)
//   start             : begin filling one word (IDLE only)
//   out_valid/ready   : output word handshake
//   out_data          : generated word, MSB = first generated bit
//   busy              : generator is filling a word
// master = generator side, slave = consumer/controller side.
interface lfsr_word_gen_if #(
  parameter int unsigned LFSR_W = 32,
  parameter int unsigned OUT_W  = 256
);
  logic              seed_load;
  logic [LFSR_W-1:0] seed_in;
  logic              start;
  logic              out_valid;
  logic              out_ready;
  logic [OUT_W-1:0]  out_data;
  logic              busy;

  modport master (
    input  seed_load, seed_in, start, out_ready,
    output out_valid, out_data, busy
  );

  modport slave (
    output seed_load, seed_in, start, out_ready,
    input  out_valid, out_data, busy
  );
endinterface

// File: rtl/lfsr_word_gen.sv
// Fibonacci LFSR word generator: steps an LFSR_W-bit LFSR one bit per clock
// and packs the feedback bits into an OUT_W-bit word (first bit at MSB).
// Ports:
//   clk     : rising-edge clock
//   reset_n : asynchronous active-low reset
//   bus     : lfsr_word_gen_if.master (seed load, start, valid/ready output, busy)
// Optional feature macro: LFSR_AUTO_RESTART_EN -- when defined, a HOLD
// handshake restarts filling immediately instead of returning to IDLE.
module lfsr_word_gen #(
  parameter int unsigned          LFSR_W = 32,
  parameter logic [LFSR_W-1:0]    TAPS   = LFSR_W'(32'hA3000000),
  parameter logic [LFSR_W-1:0]    SEED   = LFSR_W'(32'hFFFFFFFF),
  parameter int unsigned          OUT_W  = 256
) (
  input  logic clk,
  input  logic reset_n,
  lfsr_word_gen_if.master bus
);

  localparam int unsigned CNT_W = $clog2(OUT_W + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(OUT_W - 1);

  typedef enum logic [1:0] {IDLE, FILL, HOLD} state_t;

  state_t            state_q, state_d;
  logic [LFSR_W-1:0] lfsr_q, lfsr_d;
  logic [OUT_W-1:0]  sreg_q, sreg_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              valid_d, busy_d;
  logic [OUT_W-1:0]  data_d;
  logic              fb;
  logic [LFSR_W-1:0] seed_fix;

  // A zero seed would lock the LFSR, so it falls back to SEED.
  assign seed_fix = (bus.seed_in == '0) ? SEED : bus.seed_in;
  assign fb       = ^(lfsr_q & TAPS);

  // State and datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      lfsr_q        <= SEED;
      sreg_q        <= '0;
      cnt_q         <= '0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.busy      <= 1'b0;
    end else begin
      state_q       <= state_d;
      lfsr_q        <= lfsr_d;
      sreg_q        <= sreg_d;
      cnt_q         <= cnt_d;
      bus.out_valid <= valid_d;
      bus.out_data  <= data_d;
      bus.busy      <= busy_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    valid_d = bus.out_valid;
    data_d  = bus.out_data;

    unique case (state_q)
      IDLE: begin
        // Seed load wins over start; the start pulse is dropped.
        if (bus.seed_load) begin
          lfsr_d = seed_fix;
        end else if (bus.start) begin
          state_d = FILL;
          cnt_d   = '0;
          sreg_d  = '0;
        end
      end
      FILL: begin
        lfsr_d = {lfsr_q[LFSR_W-2:0], fb};
        sreg_d = {sreg_q[OUT_W-2:0], fb};
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == LAST) begin
          state_d = HOLD;
          valid_d = 1'b1;
          data_d  = sreg_d;
        end
      end
      HOLD: begin
        // Seed load here only touches the LFSR, never the held word.
        if (bus.seed_load) begin
          lfsr_d = seed_fix;
        end
        if (bus.out_ready) begin
          valid_d = 1'b0;
          data_d  = '0;
`ifdef LFSR_AUTO_RESTART_EN
          state_d = FILL;
          cnt_d   = '0;
          sreg_d  = '0;
`else
          state_d = IDLE;
`endif
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == FILL);
  end

endmodule
